// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared CPU widths, PC update encodings and fetch FSM states.
package fetch_unit_pkg;
    localparam int PC_W  = 8;
    localparam int INS_W = 16;
    typedef logic [PC_W-1:0]  pc_t;
    typedef logic [INS_W-1:0] ins_t;
    typedef enum logic [1:0] {PC_HOLD = 2'b00, PC_INC = 2'b01, PC_ABS = 2'b10, PC_REL = 2'b11} pc_ctrl_e;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} fetch_state_e;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory request/acknowledge bus.
interface fetch_unit_if;
    import fetch_unit_pkg::*;
    logic req;
    pc_t  addr;
    logic ack;
    ins_t rdata;
    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// pc_reg: program counter with hold/increment/absolute/relative update.
module pc_reg
    import fetch_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] ctrl_i,
    input  pc_t        offset_i,
    output pc_t        pc_o
);
    pc_t pc_q, pc_d;
    // 8-bit add of the raw offset equals adding its sign extension modulo 256
    always_comb
        pc_d = !en_i               ? pc_q :
               ctrl_i == PC_INC    ? pc_q + 8'd1 :
               ctrl_i == PC_ABS    ? offset_i :
               ctrl_i == PC_REL    ? pc_q + offset_i : pc_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) pc_q <= '0;
        else     pc_q <= pc_d;
    assign pc_o = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM with ack timeout, plus the program counter.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int   TIMEOUT  = 15,
    parameter ins_t NOP_WORD = 16'h0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_fetch_i,
    input  logic         en_pc_pulse_i,
    input  logic [1:0]   pc_ctrl_i,
    input  pc_t          offset_addr_i,
    fetch_unit_if.master mem,
    output ins_t         ins_o,
    output logic         en_ram_out_o,
    output pc_t          pc_o,
    output logic         busy_o,
    output logic         fetch_err_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    fetch_state_e  state_q;
    logic          req_q, pulse_q, err_q;
    pc_t           addr_q, pc;
    ins_t          ins_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout;
    pc_reg u_pc (
        .clk      (clk),
        .rst      (rst),
        .en_i     (en_pc_pulse_i),
        .ctrl_i   (pc_ctrl_i),
        .offset_i (offset_addr_i),
        .pc_o     (pc)
    );
    assign cnt_d   = cnt_q + 1'b1;
    assign timeout = cnt_d == CW'(TIMEOUT);
    // an ack arriving on the timeout cycle is checked first, so data wins
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            ins_q   <= '0;
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                IDLE: if (en_fetch_i) begin
                    state_q <= WAIT;
                    req_q   <= 1'b1;
                    addr_q  <= pc;
                    cnt_q   <= '0;
                end
                WAIT: begin
                    cnt_q <= cnt_d;
                    if (mem.ack) begin
                        ins_q   <= mem.rdata;
                        req_q   <= 1'b0;
                        state_q <= DONE;
                    end else if (timeout) begin
                        ins_q   <= NOP_WORD;
                        err_q   <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    pulse_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    assign mem.req      = req_q;
    assign mem.addr     = addr_q;
    assign ins_o        = ins_q;
    assign en_ram_out_o = pulse_q;
    assign pc_o         = pc;
    assign busy_o       = state_q != IDLE;
    assign fetch_err_o  = err_q;
endmodule
